wb_interconnect_n: RTL and testbench
====================================

WB_INTERCONNECT_N -- requirements
Module: wb_interconnect_n

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (1..8).
REQ-002 SHALL have parameter DW, default 32, data width in bits; SEL width is DW/8.
REQ-003 SHALL have parameter SLV_AW, default 9, address width passed to slaves (adr_i[SLV_AW-1:0]).
REQ-004 SHALL have parameter IDX_LSB, default 16, and IDX_WD, default 3, which locate the slave index field adr_i[IDX_LSB +: IDX_WD].
REQ-005 SHALL have parameter TIMEOUT, default 255, cycles in BUSY before forced error completion (1..65535).
REQ-006 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on error.
REQ-007 SHALL have the ports below; clock is clk_i and reset is rst, one clock, synchronous, active-high.
REQ-008 clk_i  in  1  system clock; all state changes on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 m_wb_cyc_i, m_wb_stb_i, m_wb_we_i  in  1 each  master cycle, strobe, write enable.
REQ-011 m_wb_adr_i  in  32; m_wb_dat_i  in  DW; m_wb_sel_i  in  DW/8  master address, write data, byte select.
REQ-012 m_wb_dat_o  out  DW; m_wb_ack_o  out  1; m_wb_err_o  out  1  read data, completion, error flag.
REQ-013 s_wb_cyc_o, s_wb_stb_o  out  NUM_SLAVES  one-hot per-slave cycle/strobe.
REQ-014 s_wb_we_o  out  1; s_wb_adr_o  out  SLV_AW; s_wb_dat_o  out  DW; s_wb_sel_o  out  DW/8  shared, registered, broadcast to all slaves.
REQ-015 s_wb_dat_i  in  NUM_SLAVES*DW (slave k at [k*DW +: DW]); s_wb_ack_i  in  NUM_SLAVES.
REQ-016 err_cnt_o  out  8  saturating count of error completions.

Function
REQ-017 SHALL implement FSM IDLE, BUSY, RESP.
REQ-018 IDLE: when m_wb_cyc_i&m_wb_stb_i, SHALL latch we, adr[SLV_AW-1:0], dat, sel and index; index < NUM_SLAVES -> BUSY, else RESP with error.
REQ-019 BUSY: SHALL assert s_wb_cyc_o[idx] and s_wb_stb_o[idx] only; all other bits 0.
REQ-020 BUSY: on s_wb_ack_i[idx], SHALL capture s_wb_dat_i slice idx into read register, deassert slave strobes next cycle, go RESP without error.
REQ-021 s_wb_ack_i bits of non-selected slaves, or any ack outside BUSY, SHALL be ignored.
REQ-022 BUSY: 16-bit cycle counter cleared on BUSY entry; when counter reaches TIMEOUT with no ack, SHALL go RESP with error.
REQ-023 RESP: m_wb_ack_o=1 for exactly one cycle; m_wb_err_o=1 in same cycle if error; m_wb_dat_o = captured data, or ERR_DATA on error; then IDLE.
REQ-024 m_wb_ack_o and m_wb_err_o SHALL be 0 outside RESP; m_wb_dat_o SHALL hold its last value outside RESP.
REQ-025 Latency: slave ack in first BUSY cycle gives m_wb_ack_o 3 cycles after the request-sampling edge; each extra slave wait cycle adds one.
REQ-026 m_wb_cyc_i low in BUSY SHALL abort: slave strobes low next cycle, go IDLE, no master ack, no error count.
REQ-027 Master inputs changing during BUSY SHALL not affect latched slave-side signals.
REQ-028 err_cnt_o SHALL increment by 1 on each RESP with error and saturate at 255.
REQ-029 Simultaneous slave ack and timeout in the same cycle SHALL complete as success.

Reset
REQ-030 rst SHALL force IDLE, all s_wb_cyc_o/s_wb_stb_o=0, m_wb_ack_o=0, m_wb_err_o=0, m_wb_dat_o=0, latched regs=0, counter=0, err_cnt_o=0.
REQ-031 rst asserted in BUSY or RESP SHALL take effect next edge; no ack is issued for the aborted transfer.

Verification
REQ-032 Read adr=0x3001_0004 (idx 1), slave1 acks first BUSY cycle with 0x1234_5678 -> s_wb_stb_o=4'b0010, s_wb_adr_o=9'h004, m_wb_ack_o on 3rd edge, m_wb_dat_o=0x1234_5678, err=0.
REQ-033 Write idx 3, dat 0xA5A5_0F0F, sel 4'hC, slave ack after 5 wait cycles -> slave sees we=1, dat/sel unchanged; master ack 1 cycle, latency 8.
REQ-034 Access idx 6 (NUM_SLAVES=4) -> no slave strobe, ack+err next-next cycle, m_wb_dat_o=0xDEAD_BEEF, err_cnt_o 0->1.
REQ-035 TIMEOUT=10, slave 2 never acks -> after 10 BUSY cycles ack+err, slave strobe dropped; stray slave0 ack during BUSY ignored.
REQ-036 Master drops cyc in 2nd BUSY cycle -> strobes low next edge, IDLE, no ack; rst mid-BUSY -> all outputs at reset values next edge.
REQ-037 256 consecutive error accesses -> err_cnt_o holds 255.

Source files
------------

// File: rtl/wb_interconnect_n.sv
// Single-master Wishbone interconnect fanning out to NUM_SLAVES slaves, with
// slave-index decode, a per-transfer timeout and a saturating error counter.
module wb_interconnect_n #(
  parameter int unsigned    NUM_SLAVES = 4,
  parameter int unsigned    DW         = 32,
  parameter int unsigned    SLV_AW     = 9,
  parameter int unsigned    IDX_LSB    = 16,
  parameter int unsigned    IDX_WD     = 3,
  parameter int unsigned    TIMEOUT    = 255,
  parameter logic [DW-1:0]  ERR_DATA   = DW'(32'hDEAD_BEEF)
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     m_wb_cyc_i,
  input  logic                     m_wb_stb_i,
  input  logic                     m_wb_we_i,
  input  logic [31:0]              m_wb_adr_i,
  input  logic [DW-1:0]            m_wb_dat_i,
  input  logic [DW/8-1:0]          m_wb_sel_i,
  output logic [DW-1:0]            m_wb_dat_o,
  output logic                     m_wb_ack_o,
  output logic                     m_wb_err_o,
  output logic [NUM_SLAVES-1:0]    s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_wb_stb_o,
  output logic                     s_wb_we_o,
  output logic [SLV_AW-1:0]        s_wb_adr_o,
  output logic [DW-1:0]            s_wb_dat_o,
  output logic [DW/8-1:0]          s_wb_sel_o,
  input  logic [NUM_SLAVES*DW-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_wb_ack_i,
  output logic [7:0]               err_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [IDX_WD:0] NS_LIM  = (IDX_WD+1)'(NUM_SLAVES);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [IDX_WD-1:0] idx;
  logic [IDX_WD-1:0] req_idx;
  logic [DW-1:0]     rdata;
  logic [DW-1:0]     sel_dat;
  logic [15:0]       cnt;
  logic              err_flag;
  logic              req;
  logic              idx_ok;
  logic              sel_ack;
  logic              timeout_hit;
  logic              unused_adr;

  assign req_idx     = m_wb_adr_i[IDX_LSB +: IDX_WD];
  assign idx_ok      = {1'b0, req_idx} < NS_LIM;
  // The ack is registered one cycle after RESP, so a classic master still
  // holding stb in that cycle must not be taken as a fresh request.
  assign req         = m_wb_cyc_i && m_wb_stb_i && !m_wb_ack_o;
  assign timeout_hit = (cnt == TO_LAST);
  assign unused_adr  = &{1'b0, m_wb_adr_i};
  assign s_wb_stb_o  = s_wb_cyc_o;

  always_comb begin
    sel_ack    = 1'b0;
    sel_dat    = '0;
    s_wb_cyc_o = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (idx == IDX_WD'(k)) begin
        sel_ack       = s_wb_ack_i[k];
        sel_dat       = s_wb_dat_i[k*DW +: DW];
        s_wb_cyc_o[k] = (state == BUSY);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = idx_ok ? BUSY : RESP;
      BUSY: begin
        if (!m_wb_cyc_i)                state_nx = IDLE;
        else if (sel_ack || timeout_hit) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      m_wb_dat_o <= '0;
      s_wb_we_o  <= 1'b0;
      s_wb_adr_o <= '0;
      s_wb_dat_o <= '0;
      s_wb_sel_o <= '0;
      idx        <= '0;
      rdata      <= '0;
      err_flag   <= 1'b0;
      cnt        <= '0;
      err_cnt_o  <= '0;
    end else begin
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            s_wb_we_o  <= m_wb_we_i;
            s_wb_adr_o <= m_wb_adr_i[SLV_AW-1:0];
            s_wb_dat_o <= m_wb_dat_i;
            s_wb_sel_o <= m_wb_sel_i;
            idx        <= req_idx;
            err_flag   <= !idx_ok;
            cnt        <= '0;
          end
        end
        BUSY: begin
          if (m_wb_cyc_i) begin
            // A slave ack in the timeout cycle wins over the timeout.
            if (sel_ack) begin
              rdata    <= sel_dat;
              err_flag <= 1'b0;
            end else if (timeout_hit) begin
              err_flag <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        RESP: begin
          m_wb_ack_o <= 1'b1;
          m_wb_err_o <= err_flag;
          m_wb_dat_o <= err_flag ? ERR_DATA : rdata;
          if (err_flag && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Self-checking bench for wb_interconnect_n: directed vector table, a few
// multi-cycle sequences, and random transfers against a rule-based model.
module tb_wb_interconnect_n;

  localparam int NS = 4;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_cyc, m_stb, m_we;
  logic [31:0]  m_adr, m_dat;
  logic [3:0]   m_sel;
  logic [31:0]  m_rdat;
  logic         m_ack, m_err;
  logic [3:0]   s_cyc, s_stb;
  logic         s_we;
  logic [8:0]   s_adr;
  logic [31:0]  s_wdat;
  logic [3:0]   s_sel;
  logic [127:0] s_rdat;
  logic [3:0]   s_ack;
  logic [7:0]   err_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_errs = 0;

  wb_interconnect_n #(
    .NUM_SLAVES(NS),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i     (clk),
    .rst       (rst),
    .m_wb_cyc_i(m_cyc),
    .m_wb_stb_i(m_stb),
    .m_wb_we_i (m_we),
    .m_wb_adr_i(m_adr),
    .m_wb_dat_i(m_dat),
    .m_wb_sel_i(m_sel),
    .m_wb_dat_o(m_rdat),
    .m_wb_ack_o(m_ack),
    .m_wb_err_o(m_err),
    .s_wb_cyc_o(s_cyc),
    .s_wb_stb_o(s_stb),
    .s_wb_we_o (s_we),
    .s_wb_adr_o(s_adr),
    .s_wb_dat_o(s_wdat),
    .s_wb_sel_o(s_sel),
    .s_wb_dat_i(s_rdat),
    .s_wb_ack_i(s_ack),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wait_n;
    logic [31:0] sdat;
    logic        stray;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Expected outcome derived from the transfer rules: bad index errors after
  // two edges, an ack in BUSY cycle w completes at edge w+3, otherwise timeout.
  task automatic ref_model(input logic [31:0] adr, input int w, input logic [31:0] sdat,
                           output int lat, output logic err, output logic [31:0] d);
    int i;
    i = int'(adr[18:16]);
    if (i >= NS)     begin lat = 2;      err = 1'b1; d = 32'hDEAD_BEEF; end
    else if (w < TO) begin lat = w + 3;  err = 1'b0; d = sdat;          end
    else             begin lat = TO + 2; err = 1'b1; d = 32'hDEAD_BEEF; end
  endtask

  task automatic run_txn(input string name, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int wait_n,
                         input logic [31:0] sdat, input logic stray, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_dat);
    int   idx;
    int   seen;
    int   stray_slv;
    logic valid;
    idx       = int'(adr[18:16]);
    valid     = (idx < NS);
    seen      = -1;
    stray_slv = (idx == 0) ? 1 : 0;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
    s_ack = '0;
    @(posedge clk); #1;
    m_stb = 1'b0; m_we = ~we; m_adr = $urandom; m_dat = $urandom; m_sel = ~sel;
    check({name, " stb"}, 64'(s_stb), valid ? 64'(4'b0001 << idx) : 64'd0);
    if (valid) begin
      check({name, " s_we"},  64'(s_we),   64'(we));
      check({name, " s_adr"}, 64'(s_adr),  64'(adr[8:0]));
      check({name, " s_dat"}, 64'(s_wdat), 64'(dat));
      check({name, " s_sel"}, 64'(s_sel),  64'(sel));
    end
    for (int j = 0; j < 40 && seen < 0; j++) begin
      for (int k = 0; k < NS; k++) s_rdat[k*32 +: 32] = $urandom;
      s_ack = '0;
      if (valid && j == wait_n) begin
        s_ack[idx]            = 1'b1;
        s_rdat[idx*32 +: 32]  = sdat;
      end
      if (stray && j == 1) s_ack[stray_slv] = 1'b1;
      @(posedge clk); #1;
      s_ack = '0;
      if (m_ack) seen = j + 2;
    end
    if (seen < 0) begin
      total_cnt++;
      $display("FAIL %s ack_timeout: got no ack expected ack by edge %0d", name, exp_lat);
    end else begin
      check({name, " lat"},  64'(seen),   64'(exp_lat));
      check({name, " err"},  64'(m_err),  64'(exp_err));
      check({name, " rdat"}, 64'(m_rdat), 64'(exp_dat));
      check({name, " stb_off"}, 64'(s_stb), 64'd0);
      @(posedge clk); #1;
      check({name, " ack_pulse"}, 64'({m_ack, m_err}), 64'd0);
      check({name, " rdat_hold"}, 64'(m_rdat), 64'(exp_dat));
    end
    m_cyc = 1'b0;
    if (exp_err) model_errs = (model_errs >= 255) ? 255 : model_errs + 1;
    check({name, " errcnt"}, 64'(err_cnt), 64'(model_errs));
  endtask

  initial begin
    int          lat;
    logic        err;
    logic [31:0] d, adr, sdat;
    int          w;

    rst = 1'b1; m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = '0; s_rdat = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stb",    64'({s_cyc, s_stb}), 64'd0);
    check("rst_mout",   64'({m_ack, m_err, m_rdat}), 64'd0);
    check("rst_slv",    64'({s_we, s_adr, s_wdat, s_sel}), 64'd0);
    check("rst_errcnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    tbl[0] = '{"rd_idx1",  1'b0, 32'h3001_0004, 32'h0,         4'hF, 0,    32'h1234_5678, 1'b0, 3,  1'b0, 32'h1234_5678};
    tbl[1] = '{"wr_idx3",  1'b1, 32'h0003_0010, 32'hA5A5_0F0F, 4'hC, 5,    32'h0BAD_F00D, 1'b0, 8,  1'b0, 32'h0BAD_F00D};
    tbl[2] = '{"bad_idx6", 1'b0, 32'h0006_0000, 32'h0,         4'hF, 0,    32'h1111_1111, 1'b0, 2,  1'b1, 32'hDEAD_BEEF};
    tbl[3] = '{"tmo_idx2", 1'b0, 32'h0002_0020, 32'h0,         4'hF, 1000, 32'h2222_2222, 1'b1, 12, 1'b1, 32'hDEAD_BEEF};
    tbl[4] = '{"ack_at_to",1'b0, 32'h0000_01FF, 32'h0,         4'h3, 9,    32'hCAFE_0009, 1'b0, 12, 1'b0, 32'hCAFE_0009};
    tbl[5] = '{"bad_idx7", 1'b1, 32'hFFFF_FFFF, 32'h5,         4'h1, 0,    32'h0,         1'b0, 2,  1'b1, 32'hDEAD_BEEF};
    tbl[6] = '{"rd_stray", 1'b0, 32'h0001_0100, 32'h0,         4'hF, 8,    32'h8765_4321, 1'b1, 11, 1'b0, 32'h8765_4321};
    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].name, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].wait_n,
              tbl[i].sdat, tbl[i].stray, tbl[i].exp_lat, tbl[i].exp_err, tbl[i].exp_dat);

    // Master drops cyc in the second BUSY cycle.
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0002_0040;
    @(posedge clk); #1;
    m_stb = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_stb", 64'(s_stb), 64'b0100);
    m_cyc = 1'b0;
    @(posedge clk); #1;
    check("abort_stb", 64'({s_cyc, s_stb}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("abort_noack", 64'({m_ack, m_err}), 64'd0);
      @(posedge clk); #1;
    end
    check("abort_errcnt", 64'(err_cnt), 64'(model_errs));

    // Reset in the middle of BUSY.
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h0001_0123; m_dat = 32'h7777_7777; m_sel = 4'hF;
    @(posedge clk); #1;
    m_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_errs = 0;
    check("rstb_stb",    64'({s_cyc, s_stb}), 64'd0);
    check("rstb_mout",   64'({m_ack, m_err, m_rdat}), 64'd0);
    check("rstb_slv",    64'({s_we, s_adr, s_wdat, s_sel}), 64'd0);
    check("rstb_errcnt", 64'(err_cnt), 64'd0);
    rst = 1'b0; m_cyc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstb_noack", 64'({m_ack, s_stb}), 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      adr          = $urandom;
      adr[18:16]   = 3'($urandom_range(0, 7));
      w            = $urandom_range(0, 13);
      sdat         = $urandom;
      ref_model(adr, w, sdat, lat, err, d);
      run_txn("rand", 1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom), w, sdat,
              1'($urandom_range(0, 1)), lat, err, d);
    end

    for (int n = 0; n < 256; n++)
      run_txn("err_burst", 1'b0, 32'h0005_0000, 32'h0, 4'hF, 0, 32'h0, 1'b0, 2, 1'b1, 32'hDEAD_BEEF);
    check("errcnt_sat", 64'(err_cnt), 64'd255);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
